multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multicycle ARM datapath.
- Consumes the IR-derived fields (Cond, Op, Funct, Rd) and the ALU zero bit.
- Drives every datapath select and enable, one state per cycle.
- Holds the architectural Z flag and evaluates condition codes in DECODE.

Parameters:
STATE_WIDTH, 4, width of debug state output

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
Cond  input  4  instruction[31:28]
Op  input  2  instruction[27:26]
Funct  input  6  instruction[25:20]
Rd  input  4  instruction[15:12]
Zero_bit  input  1  combinational ALU Z
pc_write_enable, address_select, memory_write_enable, IR_write_enable, reg_file_write_enable  output  1 each  datapath enables/selects
ALUsrcA, shifter_input_select, shifter_type_select, shifter_amount_select, dest_selectR14  output  1 each  datapath selects
ALUsrcB, RegSrc, ImmSrc, result_mux_select  output  2 each  datapath selects
Alu_operation_select  output  4  ALU command (ARM cmd encoding: 0100 ADD, 0010 SUB)
state_dbg  output  STATE_WIDTH  current state encoding

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset.
- Reset: while reset=1, all write enables are 0. On the first clk edge with reset=1, state=FETCH and Z=0. reset mid-instruction aborts it; no partial write occurs in that cycle.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BLINK=9, BRANCH=10. Any other value goes to FETCH.
- Outputs are Moore-style, combinational from state plus IR fields.
- Unlisted outputs in any state are 0.
- FETCH: IR_write_enable=1, address_select=0, ALUsrcA=1, ALUsrcB=10, ALU op ADD, result_mux=10, pc_write_enable=1.
- DECODE: cond check against stored Z. Passing codes: AL (1110) always; EQ (0000) if Z; NE (0001) if !Z. All other codes fail.
  - Fail, Op=11, or (Rd=15 with a register write-back) -> FETCH, executed as a NOP.
- Transitions out of DECODE:
  - Op=00, Funct[5]=0 -> EXECR; Funct[5]=1 -> EXECI.
  - Op=01 -> MEMADR.
  - Op=10, Funct[4]=1 -> BLINK; else -> BRANCH.
- RegSrc is held from DECODE to end of instruction:
  - RegSrc[0]=1 for STR.
  - RegSrc[1]=1 for branches.
  - R15 reads return current instruction address + 8.
- EXECR: ALUsrcA=0, ALUsrcB=00, shifter_input_select=0, shifter_type_select=0, shifter_amount_select=0, ALU op=Funct[4:1].
- EXECI: ALUsrcB=01, ImmSrc=00, ALU op=Funct[4:1]. The rotate field is not applied.
- EXECR/EXECI flag update: if Funct[0]=1, Z<=Zero_bit at the end of the cycle.
- CMP (cmd 1010): ALU op forced to SUB 0010, Z is always updated, next state is FETCH. All other DP commands go to ALUWB.
- ALUWB: result_mux=00, reg_file_write_enable=1, then FETCH.
- MEMADR: ALUsrcA=0, ALUsrcB=01, ImmSrc=01, ALU op ADD if Funct[3] (U) else SUB. Funct[0] (L)=1 -> MEMREAD; else -> MEMWRITE.
- MEMREAD: address_select=1, result_mux=00, then MEMWB.
- MEMWB: result_mux=01, reg_file_write_enable=1, then FETCH.
- MEMWRITE: address_select=1, result_mux=00, memory_write_enable=1, then FETCH.
- BLINK: RegSrc[1]=1, ALUsrcA=0, ALUsrcB=10, SUB, result_mux=10, dest_selectR14=1, reg_file_write_enable=1 (writes R15-4 into R14), then BRANCH.
- BRANCH: RegSrc[1]=1, ALUsrcA=0, ALUsrcB=01, ImmSrc=10, ADD, result_mux=10, pc_write_enable=1, then FETCH.
- Latency in cycles: DP 4, CMP 3, LDR 5, STR 4, B 3, BL 4, condition-failed/illegal 2.
- Z changes only in EXECR/EXECI with S set, or on CMP.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - ALU command constants (ADD, SUB, CMP);
  - ImmSrc codes (DP8, MEM12, BR24);
  - result_mux codes (ALUOUT, DATA, ALURES);
  - Cond codes (EQ, NE, AL).
- Optional sub-module cond_check: combinational (Cond, Z) -> pass.

Test Plan:
- Reset high 2 cycles, then released -> state_dbg=0, Z=0, all enables 0 during reset. First FETCH has IR_write_enable=1 and pc_write_enable=1.
- ADD: Cond=1110, Op=00, Funct=001000, Rd=1 -> states 0,1,6,8,0. EXECR op=0100. ALUWB reg_file_write_enable=1, result_mux=00.
- CMP imm: Funct=110101, Zero_bit=1 in EXECI -> states 0,1,7,0, op=0010, Z=1, no reg write.
  - Then BEQ (Cond=0000, Op=10, Funct=100000) -> BRANCH with pc_write_enable=1.
  - Then BNE (Cond=0001) -> DECODE returns to FETCH.
- LDR: Op=01, Funct=011001 -> states 0,1,2,3,4,0. MEMADR op=0100, ImmSrc=01. MEMWB result_mux=01, reg write.
- STR with U=0: Funct=010000 -> states 0,1,2,5,0. MEMADR op=0010. MEMWRITE memory_write_enable=1, RegSrc[0]=1.
- BL: Op=10, Funct=110000 -> states 0,1,9,10,0. BLINK dest_selectR14=1. reset asserted in state 3 -> next state 0, no writes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control FSM.
package ctrl_pkg;

  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BLINK    = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] IMM_DP8   = 2'b00;
  localparam logic [1:0] IMM_MEM12 = 2'b01;
  localparam logic [1:0] IMM_BR24  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // True when the instruction would write its Rd field back to the register file.
  function automatic logic writes_rd(input logic [1:0] op, input logic [5:0] funct);
    return ((op == OP_DP) && (funct[4:1] != CMD_CMP)) || ((op == OP_MEM) && funct[0]);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and ALU zero in, selects and enables out.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       Zero_bit;

  logic       pc_write_enable;
  logic       address_select;
  logic       memory_write_enable;
  logic       IR_write_enable;
  logic       reg_file_write_enable;
  logic       ALUsrcA;
  logic       shifter_input_select;
  logic       shifter_type_select;
  logic       shifter_amount_select;
  logic       dest_selectR14;
  logic [1:0] ALUsrcB;
  logic [1:0] RegSrc;
  logic [1:0] ImmSrc;
  logic [1:0] result_mux_select;
  logic [3:0] Alu_operation_select;

  modport master (
    input  Cond, Op, Funct, Rd, Zero_bit,
    output pc_write_enable, address_select, memory_write_enable, IR_write_enable,
           reg_file_write_enable, ALUsrcA, shifter_input_select, shifter_type_select,
           shifter_amount_select, dest_selectR14, ALUsrcB, RegSrc, ImmSrc,
           result_mux_select, Alu_operation_select
  );

  modport slave (
    output Cond, Op, Funct, Rd, Zero_bit,
    input  pc_write_enable, address_select, memory_write_enable, IR_write_enable,
           reg_file_write_enable, ALUsrcA, shifter_input_select, shifter_type_select,
           shifter_amount_select, dest_selectR14, ALUsrcB, RegSrc, ImmSrc,
           result_mux_select, Alu_operation_select
  );
endinterface

// File: rtl/multicycle_controller_cond_check.sv
// Condition-code evaluation against the stored Z flag (EQ, NE, AL only).
module multicycle_controller_cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       z,
  output logic       pass_c
);

  always_comb begin
    pass_c = 1'b0;
    case (cond)
      COND_EQ: pass_c = z;
      COND_NE: pass_c = !z;
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: one state per cycle, Moore outputs, holds the Z flag.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus,
  output logic [STATE_WIDTH-1:0] state_dbg
);

  state_t     state_q;
  state_t     state_d;
  logic       z_q;
  logic       z_write;
  logic       cond_pass_c;
  logic       decode_nop_c;
  logic [3:0] cmd;
  logic [3:0] dp_alu_op;
  logic       is_str;
  logic       is_branch;

  assign cmd       = bus.Funct[4:1];
  assign dp_alu_op = (cmd == CMD_CMP) ? CMD_SUB : cmd;
  assign is_str    = (bus.Op == OP_MEM) && !bus.Funct[0];
  assign is_branch = (bus.Op == OP_BR);
  assign state_dbg = STATE_WIDTH'(state_q);

  multicycle_controller_cond_check u_cond_check (
    .cond   (bus.Cond),
    .z      (z_q),
    .pass_c (cond_pass_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Architectural Z flag; reset wins over a same-cycle flag update
  always_ff @(posedge clk) begin
    if (reset)        z_q <= 1'b0;
    else if (z_write) z_q <= bus.Zero_bit;
  end

  // Next-state logic
  always_comb begin
    state_d      = S_FETCH;
    decode_nop_c = !cond_pass_c || (bus.Op == 2'b11) ||
                   ((bus.Rd == 4'd15) && writes_rd(bus.Op, bus.Funct));
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (decode_nop_c)          state_d = S_FETCH;
        else if (bus.Op == OP_DP)  state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
        else if (bus.Op == OP_MEM) state_d = S_MEMADR;
        else                       state_d = bus.Funct[4] ? S_BLINK : S_BRANCH;
      end
      S_MEMADR:         state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:        state_d = S_MEMWB;
      S_EXECR, S_EXECI: state_d = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
      S_BLINK:          state_d = S_BRANCH;
      default:          state_d = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    bus.pc_write_enable       = 1'b0;
    bus.address_select        = 1'b0;
    bus.memory_write_enable   = 1'b0;
    bus.IR_write_enable       = 1'b0;
    bus.reg_file_write_enable = 1'b0;
    bus.ALUsrcA               = 1'b0;
    bus.shifter_input_select  = 1'b0;
    bus.shifter_type_select   = 1'b0;
    bus.shifter_amount_select = 1'b0;
    bus.dest_selectR14        = 1'b0;
    bus.ALUsrcB               = SRCB_REG;
    bus.RegSrc                = 2'b00;
    bus.ImmSrc                = IMM_DP8;
    bus.result_mux_select     = RES_ALUOUT;
    bus.Alu_operation_select  = 4'b0000;
    z_write                   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.IR_write_enable      = 1'b1;
        bus.pc_write_enable      = 1'b1;
        bus.ALUsrcA              = 1'b1;
        bus.ALUsrcB              = SRCB_FOUR;
        bus.Alu_operation_select = CMD_ADD;
        bus.result_mux_select    = RES_ALURES;
      end
      S_DECODE: bus.RegSrc = {is_branch, is_str};
      S_EXECR: begin
        bus.ALUsrcB              = SRCB_REG;
        bus.Alu_operation_select = dp_alu_op;
        z_write                  = bus.Funct[0] || (cmd == CMD_CMP);
      end
      S_EXECI: begin
        bus.ALUsrcB              = SRCB_IMM;
        bus.ImmSrc               = IMM_DP8;
        bus.Alu_operation_select = dp_alu_op;
        z_write                  = bus.Funct[0] || (cmd == CMD_CMP);
      end
      S_ALUWB: begin
        bus.result_mux_select     = RES_ALUOUT;
        bus.reg_file_write_enable = 1'b1;
      end
      S_MEMADR: begin
        bus.RegSrc               = {1'b0, is_str};
        bus.ALUsrcB              = SRCB_IMM;
        bus.ImmSrc               = IMM_MEM12;
        bus.Alu_operation_select = bus.Funct[3] ? CMD_ADD : CMD_SUB;
      end
      S_MEMREAD: begin
        bus.address_select    = 1'b1;
        bus.result_mux_select = RES_ALUOUT;
      end
      S_MEMWB: begin
        bus.result_mux_select     = RES_DATA;
        bus.reg_file_write_enable = 1'b1;
      end
      S_MEMWRITE: begin
        bus.RegSrc              = 2'b01;
        bus.address_select      = 1'b1;
        bus.result_mux_select   = RES_ALUOUT;
        bus.memory_write_enable = 1'b1;
      end
      S_BLINK: begin
        bus.RegSrc                = 2'b10;
        bus.ALUsrcB               = SRCB_FOUR;
        bus.Alu_operation_select  = CMD_SUB;
        bus.result_mux_select     = RES_ALURES;
        bus.dest_selectR14        = 1'b1;
        bus.reg_file_write_enable = 1'b1;
      end
      S_BRANCH: begin
        bus.RegSrc               = 2'b10;
        bus.ALUsrcB              = SRCB_IMM;
        bus.ImmSrc               = IMM_BR24;
        bus.Alu_operation_select = CMD_ADD;
        bus.result_mux_select    = RES_ALURES;
        bus.pc_write_enable      = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every write, including one mid-instruction
    if (reset) begin
      bus.pc_write_enable       = 1'b0;
      bus.memory_write_enable   = 1'b0;
      bus.IR_write_enable       = 1'b0;
      bus.reg_file_write_enable = 1'b0;
      z_write                   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: instruction-level reference model predicts every cycle's outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic       mz = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.STATE_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc, addr, mem, ir, rf, srca, shin, shty, sham, d14;
    logic [1:0] srcb, regsrc, imm, res;
    logic [3:0] alu;
  } obs_t;

  obs_t expq[$];

  // Expected outputs for one state of an instruction, straight from the per-state listing
  function automatic obs_t exp_out(input int st, input logic [1:0] op, input logic [5:0] f);
    obs_t e;
    logic [3:0] cmd;
    e = '0;
    cmd = f[4:1];
    e.st = 4'(st);
    case (st)
      0: begin e.ir = 1; e.pc = 1; e.srca = 1; e.srcb = 2'b10; e.alu = 4'b0100; e.res = 2'b10; end
      1: e.regsrc = {op == 2'b10, (op == 2'b01) && !f[0]};
      2: begin
        e.regsrc = {1'b0, !f[0]}; e.srcb = 2'b01; e.imm = 2'b01;
        e.alu = f[3] ? 4'b0100 : 4'b0010;
      end
      3: e.addr = 1;
      4: begin e.res = 2'b01; e.rf = 1; end
      5: begin e.addr = 1; e.mem = 1; e.regsrc = 2'b01; end
      6: e.alu = (cmd == 4'b1010) ? 4'b0010 : cmd;
      7: begin e.srcb = 2'b01; e.alu = (cmd == 4'b1010) ? 4'b0010 : cmd; end
      8: e.rf = 1;
      9: begin e.regsrc = 2'b10; e.srcb = 2'b10; e.alu = 4'b0010; e.res = 2'b10; e.d14 = 1; e.rf = 1; end
      10: begin e.regsrc = 2'b10; e.srcb = 2'b01; e.imm = 2'b10; e.alu = 4'b0100; e.res = 2'b10; e.pc = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: every cycle with a pending prediction is compared
  always @(negedge clk) begin
    obs_t a, e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {state_dbg, bus.pc_write_enable, bus.address_select, bus.memory_write_enable,
           bus.IR_write_enable, bus.reg_file_write_enable, bus.ALUsrcA, bus.shifter_input_select,
           bus.shifter_type_select, bus.shifter_amount_select, bus.dest_selectR14, bus.ALUsrcB,
           bus.RegSrc, bus.ImmSrc, bus.result_mux_select, bus.Alu_operation_select};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_cycle t=%0t: state got %0d exp %0d, outputs got %h exp %h",
                 $time, a.st, e.st, a, e);
      end
    end
  end

  // Runs one instruction; abort_at>=0 asserts reset during that step of the instruction
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic zb, input int abort_at);
    int   path[$];
    obs_t e;
    logic pass, writes, is_cmp;
    bus.Cond = c; bus.Op = o; bus.Funct = f; bus.Rd = r; bus.Zero_bit = zb;
    pass   = (c == 4'b1110) || ((c == 4'b0000) && mz) || ((c == 4'b0001) && !mz);
    is_cmp = (f[4:1] == 4'b1010);
    writes = ((o == 2'b00) && !is_cmp) || ((o == 2'b01) && f[0]);
    path = '{0, 1};
    if (pass && (o != 2'b11) && !((r == 4'd15) && writes)) begin
      case (o)
        2'b00: begin path.push_back(f[5] ? 7 : 6); if (!is_cmp) path.push_back(8); end
        2'b01: begin path.push_back(2); if (f[0]) begin path.push_back(3); path.push_back(4); end
                     else path.push_back(5); end
        default: begin if (f[4]) path.push_back(9); path.push_back(10); end
      endcase
    end
    foreach (path[i]) begin
      e = exp_out(path[i], o, f);
      if (i == abort_at) begin
        e.pc = 0; e.mem = 0; e.ir = 0; e.rf = 0;
        expq.push_back(e);
        break;
      end
      expq.push_back(e);
    end
    foreach (path[i]) begin
      if (i == abort_at) reset = 1'b1;
      @(posedge clk); #1;
      if (i == abort_at) begin
        reset = 1'b0;
        mz = 1'b0;
        return;
      end
    end
    if (pass && (o == 2'b00) && (r != 4'd15 || is_cmp) && (f[0] || is_cmp)) mz = zb;
  endtask

  initial begin
    obs_t e;
    logic [3:0] c, r;
    logic [1:0] o;
    logic [5:0] f;
    int ab;
    bus.Cond = 4'd0; bus.Op = 2'd0; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.Zero_bit = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    e = exp_out(0, 2'b00, 6'd0);
    e.pc = 0; e.ir = 0;
    expq.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;
    mz = 1'b0;

    run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 1'b0, -1);   // ADD
    run_instr(4'b1110, 2'b00, 6'b110101, 4'd0, 1'b1, -1);   // CMP imm, Z=1
    run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 1'b0, -1);   // BEQ taken
    run_instr(4'b0001, 2'b10, 6'b100000, 4'd0, 1'b0, -1);   // BNE not taken
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 1'b0, -1);   // LDR
    run_instr(4'b1110, 2'b01, 6'b010000, 4'd3, 1'b0, -1);   // STR, U=0
    run_instr(4'b1110, 2'b10, 6'b110000, 4'd0, 1'b0, -1);   // BL
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 1'b0, 3);    // LDR aborted in MEMREAD
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 1'b0, 3);    // ADD aborted in ALUWB
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd15, 1'b0, -1);  // write to R15 -> NOP
    run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 1'b0, -1);   // Op=11 -> NOP
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd15, 1'b1, -1);  // CMP reg with Rd=15 still runs
    run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 1'b0, -1);   // BEQ taken
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd4, 1'b0, 2);    // ADDS aborted in EXECR, Z cleared
    run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 1'b0, -1);   // BEQ not taken

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: c = 4'b1110;
        3:       c = 4'b0000;
        4:       c = 4'b0001;
        default: c = 4'($urandom);
      endcase
      o = 2'($urandom);
      f = 6'($urandom);
      if ((o == 2'b00) && ($urandom_range(0, 2) == 0)) f[4:1] = 4'b1010;
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(c, o, f, r, 1'($urandom), ab);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending got %0d exp 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
